instr_fetch: RTL

Fetch unit that drives the instruction ROM address and captures the 9-bit machine code it returns into an instruction register for the decoder. It owns the program counter and handles start-up, sequential fetch, absolute and relative branches, stalls and halt. It sits between the instruction ROM (combinational read, prog_ctr in, mach_code out) and the core's decode stage.

---
 rtl/instr_fetch.sv | 90 +++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the program counter, drives the ROM address and
// registers the returned machine code for decode, with branch, stall and halt.
module instr_fetch #(
  parameter int D          = 12,
  parameter int W          = 9,
  parameter int START_ADDR = 0,
  parameter int OFS_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  input  logic             jump_en,
  input  logic [D-1:0]     jump_target,
  input  logic             rel_en,
  input  logic [OFS_W-1:0] rel_offset,
  input  logic             halt_req,
  input  logic [W-1:0]     mach_code,
  output logic [D-1:0]     prog_ctr,
  output logic [W-1:0]     instr,
  output logic [D-1:0]     instr_pc,
  output logic             instr_valid,
  output logic             busy,
  output logic             done,
  output logic [15:0]      fetch_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;

  logic [1:0]   state;
  logic [D-1:0] start_pc;
  logic [D-1:0] rel_target;

  assign start_pc   = D'(START_ADDR);
  assign rel_target = instr_pc
                    + {{(D-OFS_W){rel_offset[OFS_W-1]}}, rel_offset};
  assign busy = (state == RUN);
  assign done = (state == HALTED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      prog_ctr    <= start_pc;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            state       <= RUN;
            prog_ctr    <= start_pc;
            instr_valid <= 1'b0;
            fetch_count <= '0;
          end
        end
        RUN: begin
          // Halt outranks stall so a stalled halt instruction still retires
          if (halt_req && instr_valid) begin
            state       <= HALTED;
            instr_valid <= 1'b0;
          end else if (stall) begin
            state <= RUN;
          end else if (jump_en && instr_valid) begin
            prog_ctr    <= jump_target;
            instr_valid <= 1'b0;
          end else if (rel_en && instr_valid) begin
            prog_ctr    <= rel_target;
            instr_valid <= 1'b0;
          end else begin
            instr       <= mach_code;
            instr_pc    <= prog_ctr;
            instr_valid <= 1'b1;
            prog_ctr    <= prog_ctr + 1'b1;
            if (fetch_count != 16'hFFFF)
              fetch_count <= fetch_count + 16'd1;
          end
        end
        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
